// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - Word/address/data width constants.
//   - Fetch state encoding (RUN / FAULT).
//   - Prefetch buffer entry: the instruction word together with its PC.
//   - Fetch address legality helper.
package imem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  // A fetch address is illegal past the last full word of memory or when it
  // is not word aligned.
  function automatic logic addr_illegal(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] last_addr);
    return (addr > last_addr) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (pointers/count only)
//   push_i      : write wdata_i at the tail (caller guarantees space)
//   pop_i       : drop the head entry (caller guarantees non-empty)
//   flush_i     : empty the FIFO; overrides push and pop in the same cycle
//   wdata_i     : entry to push
//   head_o      : current head entry (meaningful only while count_o != 0)
//   count_o     : number of valid entries
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: initiator side of the instruction-memory interface.
// Keeps the PC, issues one word request at a time, buffers returned words in
// a small prefetch FIFO and presents them to decode over valid/ready. Branch
// redirects flush the buffer and discard an in-flight response; illegal
// fetch addresses raise a sticky fault instead of issuing.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_req, imem_addr        : one-cycle request strobe and word address
//   imem_rvalid, imem_rdata    : response strobe and instruction word
//   inst_valid, inst_ready     : decode handshake
//   inst_data, inst_pc         : head instruction and its PC
//   redirect_valid, redirect_pc: branch/jump redirect
//   fault, fault_addr          : sticky fetch fault and offending address
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              out_q, out_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  logic              resp;
  logic              push;
  logic              pop;
  logic              out_after;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  cnt_after;
  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_wdata;

  // A response only counts while our request is outstanding; this is what
  // makes a stale response from before reset harmless.
  assign resp       = imem_rvalid & out_q;
  // A response coinciding with a redirect is the outstanding one and is
  // dropped without arming kill.
  assign push       = resp & ~kill_q & ~redirect_valid;
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign out_after  = out_q & ~resp;
  assign cnt_after  = redirect_valid ? '0
                                     : fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign fifo_wdata = '{pc: req_pc_q, data: imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Next-state logic. The issue decision looks at the state as it will be
  // after this edge (post-response PC, post-pop count), so the request
  // strobe is registered yet a new request still appears the cycle right
  // after a response. Space is reserved for the in-flight word by requiring
  // the post-edge count to be below depth.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    out_d        = out_after;
    kill_d       = kill_q;
    req_d        = 1'b0;
    addr_d       = addr_q;
    fault_addr_d = fault_addr_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = RUN;
      kill_d  = out_after;
    end else if (resp) begin
      if (kill_q) kill_d = 1'b0;
      else        pc_d   = req_pc_q + ADDR_W'(WORD_BYTES);
    end

    if (state_d == RUN && !out_after && cnt_after < CNT_W'(FIFO_DEPTH)) begin
      if (addr_illegal(pc_d, LAST_ADDR)) begin
        state_d      = FAULT;
        fault_addr_d = pc_d;
      end else begin
        req_d    = 1'b1;
        addr_d   = pc_d;
        req_pc_d = pc_d;
        out_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      out_q        <= 1'b0;
      kill_q       <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_q        <= out_d;
      kill_q       <= kill_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (fifo_count != '0);
  // Head is masked while empty so the outputs read zero without resetting
  // the FIFO storage.
  assign inst_data  = inst_valid ? fifo_head.data : '0;
  assign inst_pc    = inst_valid ? fifo_head.pc   : '0;
  assign fault      = (state_q == FAULT);
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_addr;

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .MEM_BYTES  (MEM_BYTES),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_addr     (fault_addr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory contents: word at byte address a is 0x11111111 * (a/4 + 1).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_1111 * ((a >> 2) + 32'd1);
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
    return (a > 32'(MEM_BYTES - 4)) || (a % 4 != 0);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] addr;
  } resp_t;

  resp_t       pend[$];
  // stimulus intent for the next cycle
  bit          rst_nx, rdy_nx, rdir_nx;
  logic [31:0] rdir_pc_nx;
  int          lat_min = 1, lat_max = 1;
  // reference model: program-order fetch and delivery pointers
  logic [31:0] exp_fetch, exp_pop;
  bit          m_out, prev_fault, prev_redir;
  int          cyc = 0;
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pop_log[$];

  // One clock cycle: observe outputs and drive inputs at the falling edge.
  task automatic step();
    resp_t       r;
    bit          rv;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;
    rv = 1'b0;
    rd = 32'h0;
    if (imem_req) begin
      check("req_addr", imem_addr, exp_fetch);
      check("req_legal", 32'(bad_addr(imem_addr)), 32'd0);
      check("req_while_busy", 32'(m_out), 32'd0);
      exp_fetch += 32'd4;
      m_out = 1'b1;
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      r.addr = imem_addr;
      pend.push_back(r);
    end
    if (fault) begin
      if (!prev_fault || prev_redir) check("fault_addr", fault_addr, exp_fetch);
      check("req_in_fault", 32'(imem_req), 32'd0);
    end
    if (prev_redir) check("flush", 32'(inst_valid), 32'd0);
    prev_fault = fault;
    prev_redir = 1'b0;

    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_rvalid    = rv;
    imem_rdata     = rv ? rd : $urandom;
    rst_n          = rst_nx;
    inst_ready     = rdy_nx;
    redirect_valid = rdir_nx;
    redirect_pc    = rdir_pc_nx;

    if (!rst_nx) begin
      exp_fetch  = RESET_PC;
      exp_pop    = RESET_PC;
      m_out      = 1'b0;
      prev_fault = 1'b0;
    end else begin
      if (rv) m_out = 1'b0;
      if (inst_valid && rdy_nx && !rdir_nx) begin
        check("inst_pc", inst_pc, exp_pop);
        check("inst_data", inst_data, mem_word(exp_pop));
        pop_log.push_back(inst_pc);
        exp_pop += 32'd4;
      end
      if (rdir_nx) begin
        exp_fetch  = rdir_pc_nx;
        exp_pop    = rdir_pc_nx;
        prev_redir = 1'b1;
      end
    end
    rdir_nx = 1'b0;
  endtask

  task automatic do_reset();
    rst_nx = 1'b0;
    repeat (2) step();
    rst_nx = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    rdir_nx    = 1'b1;
    rdir_pc_nx = a;
    step();
    req_log.delete();
    req_cyc.delete();
  endtask

  task automatic wait_req(input logic [31:0] a, input int max_cyc);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (imem_req && imem_addr == a) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_req", 32'(hit), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n8;
    bit found;
    logic [31:0] tgt;
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    rst_nx = 1'b0; rdy_nx = 1'b0; rdir_nx = 1'b0; rdir_pc_nx = 32'h0;

    // reset state
    do_reset();
    check_reset_outputs();

    // sequential fetch, latency 1
    rdy_nx = 1'b1;
    req_log.delete(); req_cyc.delete();
    repeat (8) step();
    check("seq_nreq", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) check("seq_addr", req_log[i], 32'(4 * i));
      for (int i = 1; i < 3; i++) check("seq_gap", 32'(req_cyc[i] - req_cyc[i-1]), 32'd2);
    end

    // backpressure
    do_reset();
    rdy_nx = 1'b0;
    req_log.delete();
    repeat (10) step();
    check("bp_nreq", 32'(req_log.size()), 32'd2);
    check("bp_idle", 32'(imem_req), 32'd0);
    rdy_nx = 1'b1;
    pop_log.delete(); req_log.delete();
    repeat (8) step();
    check("bp_npop", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      check("bp_pop0", pop_log[0], 32'h0);
      check("bp_pop1", pop_log[1], 32'h4);
    end
    check("bp_resume_n", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("bp_resume", req_log[0], 32'h8);

    // redirect with a request in flight, latency 3
    do_reset();
    lat_min = 3; lat_max = 3;
    rdy_nx = 1'b1;
    wait_req(32'h8, 30);
    pop_log.delete();
    redirect_to(32'h100);
    repeat (14) step();
    check("rd_nreq", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("rd_first", req_log[0], 32'h100);
    n8 = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h8) n8++;
    check("rd_no_stale", 32'(n8), 32'd0);

    // end-of-memory fault
    lat_min = 1; lat_max = 1;
    pop_log.delete();
    redirect_to(32'h3FC);
    repeat (8) step();
    check("bnd_fault", 32'(fault), 32'd1);
    check("bnd_fault_addr", fault_addr, 32'h400);
    check("bnd_nreq", 32'(req_log.size()), 32'd1);
    found = 1'b0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h3FC) found = 1'b1;
    check("bnd_last_word", 32'(found), 32'd1);
    redirect_to(32'h0);
    repeat (6) step();
    check("bnd_clear", 32'(fault), 32'd0);
    check("bnd_resume_n", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("bnd_resume", req_log[0], 32'h0);

    // misaligned redirect
    redirect_to(32'h102);
    repeat (4) step();
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_fault_addr", fault_addr, 32'h102);
    check("mis_nreq", 32'(req_log.size()), 32'd0);

    // reset with a request outstanding and a word buffered
    lat_min = 3; lat_max = 3;
    rdy_nx = 1'b0;
    redirect_to(32'h200);
    wait_req(32'h204, 30);
    rst_nx = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_nx = 1'b1;
    req_log.delete();
    repeat (7) step();
    check("rst_req_n", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("rst_first_req", req_log[0], RESET_PC);
    rdy_nx = 1'b1;
    repeat (10) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      lat_min = 1; lat_max = 4;
      rdy_nx = ($urandom_range(3, 0) != 0);
      if ($urandom_range(11, 0) == 0) begin
        case ($urandom_range(9, 0))
          0:       tgt = 32'h3F0 + 32'($urandom_range(3, 0) * 4);
          1:       tgt = (32'($urandom_range(255, 0)) << 2) | 32'($urandom_range(3, 1));
          2:       tgt = 32'h400 + (32'($urandom_range(1023, 0)) << 2);
          default: tgt = 32'($urandom_range(255, 0)) << 2;
        endcase
        rdir_nx    = 1'b1;
        rdir_pc_nx = tgt;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
